// File: rtl/router_dest_reader_if.sv
// router_dest_reader_if: port bundle between one router output port and its
// destination reader.
// Signals:
//   vld_out, data_out, soft_reset - router FIFO status, read data and soft reset
//   read_enb                      - registered FIFO read request from the reader
//   byte_valid/byte_data/byte_last - captured byte stream
//   pkt_addr, pkt_len             - header fields of the current/last packet
//   pkt_done, parity_err, addr_err, pkt_abort, busy, pkt_cnt - packet status
// Modports: slave = reader side, master = router/environment side.
interface router_dest_reader_if #(
    parameter int unsigned CNT_W = 16
);
    logic             vld_out;
    logic [7:0]       data_out;
    logic             soft_reset;
    logic             read_enb;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             byte_last;
    logic [1:0]       pkt_addr;
    logic [5:0]       pkt_len;
    logic             pkt_done;
    logic             parity_err;
    logic             addr_err;
    logic             pkt_abort;
    logic             busy;
    logic [CNT_W-1:0] pkt_cnt;

    modport slave (
        input  vld_out, data_out, soft_reset,
        output read_enb, byte_valid, byte_data, byte_last, pkt_addr, pkt_len,
               pkt_done, parity_err, addr_err, pkt_abort, busy, pkt_cnt
    );

    modport master (
        output vld_out, data_out, soft_reset,
        input  read_enb, byte_valid, byte_data, byte_last, pkt_addr, pkt_len,
               pkt_done, parity_err, addr_err, pkt_abort, busy, pkt_cnt
    );
endinterface

// File: rtl/router_dest_reader.sv
// router_dest_reader: pulls one complete packet at a time out of a router
// output FIFO, presents every byte on a strobe stream, checks header address
// and XOR parity, and counts completed packets.
// Ports:
//   clock_i - single clock, rising edge
//   reset_i - synchronous, active-high
//   bus     - router_dest_reader_if.slave (FIFO handshake in, stream/status out)
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | vld_out must persist READ_WAIT cycles before reading
// HDR_REQ  | read_enb held high until the header read is effective
// HDR_WAIT | header byte arriving; latch addr/len, reopen reads
// BODY     | payload + parity reads, remaining counts down to 1
// DRAIN    | last (parity) byte arriving
// DONE     | report pkt_done with error flags, bump pkt_cnt
module router_dest_reader #(
    parameter int unsigned PORT_ID   = 0,
    parameter int unsigned READ_WAIT = 0,
    parameter int unsigned CNT_W     = 16
) (
    input logic                 clock_i,
    input logic                 reset_i,
    router_dest_reader_if.slave bus
);

    localparam logic [1:0] PORT_ADDR = 2'(PORT_ID);
    localparam logic [4:0] WAIT_LD   = 5'(READ_WAIT);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_REQ, S_HDR_WAIT, S_BODY, S_DRAIN, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             read_enb_q, read_enb_d;
    logic             pend_q, pend_d;
    logic [4:0]       wait_cnt_q, wait_cnt_d;
    logic [6:0]       remaining_q, remaining_d;
    logic [7:0]       par_q, par_d;
    logic             byte_valid_q, byte_valid_d;
    logic [7:0]       byte_data_q, byte_data_d;
    logic             byte_last_q, byte_last_d;
    logic [1:0]       pkt_addr_q, pkt_addr_d;
    logic [5:0]       pkt_len_q, pkt_len_d;
    logic             pkt_done_q, pkt_done_d;
    logic             parity_err_q, parity_err_d;
    logic             addr_err_q, addr_err_d;
    logic             pkt_abort_q, pkt_abort_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

    // The FIFO ignores reads while empty, so only these reads are counted.
    logic eff_rd;
    assign eff_rd = read_enb_q & bus.vld_out;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            read_enb_q   <= 1'b0;
            pend_q       <= 1'b0;
            wait_cnt_q   <= WAIT_LD;
            remaining_q  <= '0;
            par_q        <= '0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= '0;
            byte_last_q  <= 1'b0;
            pkt_addr_q   <= '0;
            pkt_len_q    <= '0;
            pkt_done_q   <= 1'b0;
            parity_err_q <= 1'b0;
            addr_err_q   <= 1'b0;
            pkt_abort_q  <= 1'b0;
            pkt_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            read_enb_q   <= read_enb_d;
            pend_q       <= pend_d;
            wait_cnt_q   <= wait_cnt_d;
            remaining_q  <= remaining_d;
            par_q        <= par_d;
            byte_valid_q <= byte_valid_d;
            byte_data_q  <= byte_data_d;
            byte_last_q  <= byte_last_d;
            pkt_addr_q   <= pkt_addr_d;
            pkt_len_q    <= pkt_len_d;
            pkt_done_q   <= pkt_done_d;
            parity_err_q <= parity_err_d;
            addr_err_q   <= addr_err_d;
            pkt_abort_q  <= pkt_abort_d;
            pkt_cnt_q    <= pkt_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        read_enb_d   = read_enb_q;
        pend_d       = 1'b0;
        wait_cnt_d   = wait_cnt_q;
        remaining_d  = remaining_q;
        par_d        = par_q;
        byte_valid_d = 1'b0;
        byte_data_d  = byte_data_q;
        byte_last_d  = 1'b0;
        pkt_addr_d   = pkt_addr_q;
        pkt_len_d    = pkt_len_q;
        pkt_done_d   = 1'b0;
        parity_err_d = 1'b0;
        addr_err_d   = 1'b0;
        pkt_abort_d  = 1'b0;
        pkt_cnt_d    = pkt_cnt_q;

        // Byte read at the previous edge lands now.
        if (pend_q) begin
            byte_valid_d = 1'b1;
            byte_data_d  = bus.data_out;
            par_d        = par_q ^ bus.data_out;
            byte_last_d  = (state_q == S_DRAIN);
        end

        case (state_q)
            S_IDLE: begin
                read_enb_d = 1'b0;
                // wait_cnt is a down-counter reloaded whenever the wait restarts.
                if (bus.soft_reset || !bus.vld_out) begin
                    wait_cnt_d = WAIT_LD;
                end else if (wait_cnt_q != 5'd0) begin
                    wait_cnt_d = wait_cnt_q - 5'd1;
                end else begin
                    wait_cnt_d = WAIT_LD;
                    read_enb_d = 1'b1;
                    par_d      = '0;
                    state_d    = S_HDR_REQ;
                end
            end
            S_HDR_REQ: begin
                if (eff_rd) begin
                    read_enb_d = 1'b0;
                    pend_d     = 1'b1;
                    state_d    = S_HDR_WAIT;
                end
            end
            S_HDR_WAIT: begin
                pkt_addr_d  = bus.data_out[1:0];
                pkt_len_d   = bus.data_out[7:2];
                // payload bytes plus the trailing parity byte
                remaining_d = {1'b0, bus.data_out[7:2]} + 7'd1;
                read_enb_d  = 1'b1;
                state_d     = S_BODY;
            end
            S_BODY: begin
                if (eff_rd) begin
                    pend_d      = 1'b1;
                    remaining_d = remaining_q - 7'd1;
                    if (remaining_q == 7'd1) begin
                        read_enb_d = 1'b0;
                        state_d    = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                pkt_done_d   = 1'b1;
                parity_err_d = (par_q != 8'd0);
                addr_err_d   = (pkt_addr_q != PORT_ADDR);
                pkt_cnt_d    = pkt_cnt_q + CNT_W'(1);
                state_d      = S_IDLE;
            end
            default: begin
                state_d    = S_IDLE;
                read_enb_d = 1'b0;
            end
        endcase

        // Soft reset kills a packet in flight; it overrides any capture or done.
        if (bus.soft_reset && (state_q != S_IDLE)) begin
            state_d      = S_IDLE;
            read_enb_d   = 1'b0;
            pend_d       = 1'b0;
            wait_cnt_d   = WAIT_LD;
            remaining_d  = remaining_q;
            par_d        = par_q;
            byte_valid_d = 1'b0;
            byte_data_d  = byte_data_q;
            byte_last_d  = 1'b0;
            pkt_addr_d   = pkt_addr_q;
            pkt_len_d    = pkt_len_q;
            pkt_done_d   = 1'b0;
            parity_err_d = 1'b0;
            addr_err_d   = 1'b0;
            pkt_cnt_d    = pkt_cnt_q;
            pkt_abort_d  = 1'b1;
        end
    end

    assign bus.read_enb   = read_enb_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.byte_data  = byte_data_q;
    assign bus.byte_last  = byte_last_q;
    assign bus.pkt_addr   = pkt_addr_q;
    assign bus.pkt_len    = pkt_len_q;
    assign bus.pkt_done   = pkt_done_q;
    assign bus.parity_err = parity_err_q;
    assign bus.addr_err   = addr_err_q;
    assign bus.pkt_abort  = pkt_abort_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.pkt_cnt    = pkt_cnt_q;

endmodule
